vavg_seq: RTL and testbench

VAVG_SEQ -- requirements
Module: vavg_seq

---
 rtl/vavg_seq_if.sv | 24 ++
 rtl/vavg_seq.sv | 84 ++++++++
 tb/tb_vavg_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vavg_seq_if.sv
// Operand/result handshake bundle for the sequential halfword averager.
interface vavg_seq_if #(
    parameter int unsigned NBEAT = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_uns;
    logic [32*NBEAT-1:0]   vra;
    logic [32*NBEAT-1:0]   vrb;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*NBEAT-1:0]   vrt;
    logic                  busy;

    modport master (
        output in_valid, in_uns, vra, vrb, out_ready,
        input  in_ready, out_valid, vrt, busy
    );

    modport slave (
        input  in_valid, in_uns, vra, vrb, out_ready,
        output in_ready, out_valid, vrt, busy
    );
endinterface

// File: rtl/vavg_seq.sv
// Sequential rounded halfword average of two vectors, one 32-bit word per cycle.
// Operands are latched at accept so the caller may change them during the run.
module vavg_seq #(
    parameter int unsigned NBEAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    vavg_seq_if.slave   bus
);
    localparam int unsigned W  = 32 * NBEAT;
    localparam int unsigned BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BW-1:0] LastBeat = BW'(NBEAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [BW-1:0]   r_beat;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic            r_uns;
    logic            w_accept;
    logic [31:0]     w_word_a;
    logic [31:0]     w_word_b;
    logic [31:0]     w_word_res;

    // 17-bit sum of extended halfwords plus one, keep bits [16:1]; cannot overflow.
    function automatic logic [15:0] half_avg(input logic [15:0] a, input logic [15:0] b,
                                             input logic uns);
        logic [16:0] sum;
        sum = {~uns & a[15], a} + {~uns & b[15], b} + 17'd1;
        return sum[16:1];
    endfunction

    assign w_accept   = bus.in_valid && (r_state == StIdle);
    assign w_word_a   = r_a[{r_beat, 5'b0} +: 32];
    assign w_word_b   = r_b[{r_beat, 5'b0} +: 32];
    assign w_word_res = {half_avg(w_word_a[31:16], w_word_b[31:16], r_uns),
                         half_avg(w_word_a[15:0],  w_word_b[15:0],  r_uns)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.in_valid) w_state_next = StRun;
            StRun:   if (r_beat == LastBeat) w_state_next = StDone;
            StDone:  if (bus.out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_uns  <= 1'b0;
            r_res  <= '0;
        end else if (w_accept) begin
            r_beat <= '0;
            r_a    <= bus.vra;
            r_b    <= bus.vrb;
            r_uns  <= bus.in_uns;
        end else if (r_state == StRun) begin
            r_res[{r_beat, 5'b0} +: 32] <= w_word_res;
            if (r_beat != LastBeat) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.busy      = (r_state == StRun) || (r_state == StDone);
    assign bus.vrt       = r_res;
endmodule

// File: tb/tb_vavg_seq.sv
// Directed and scoreboarded checks for vavg_seq with NBEAT = 4.
module tb_vavg_seq;
    localparam int unsigned NBEAT = 4;
    localparam int W = 32 * NBEAT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vavg_seq_if #(.NBEAT(NBEAT)) bus();

    vavg_seq #(.NBEAT(NBEAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: integer arithmetic average with round-half-up.
    function automatic logic [W-1:0] ref_avg(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic uns);
        logic [W-1:0] res;
        logic [15:0]  ha;
        logic [15:0]  hb;
        int           x;
        int           y;
        int           r;
        for (int i = 0; i < 2 * NBEAT; i++) begin
            ha = a[16*i +: 16];
            hb = b[16*i +: 16];
            x  = uns ? int'({16'h0, ha}) : int'($signed(ha));
            y  = uns ? int'({16'h0, hb}) : int'($signed(hb));
            r  = (x + y + 1) >>> 1;
            res[16*i +: 16] = r[15:0];
        end
        return res;
    endfunction

    // Handshake one vector with out_ready high and check latency, result and release.
    task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic uns, input logic [W-1:0] exp);
        int lat;
        bus.vra = a;
        bus.vrb = b;
        bus.in_uns = uns;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        check({tag, "_rdy"}, W'(bus.in_ready), W'(1'b1));
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, W'(lat), W'(5));
        check({tag, "_vrt"}, bus.vrt, exp);
        step();
        check({tag, "_ovdrop"}, W'(bus.out_valid), W'(1'b0));
        check({tag, "_idle"}, W'(bus.in_ready), W'(1'b1));
    endtask

    logic [W-1:0] sa;
    logic [W-1:0] sb;
    logic         su;
    logic [W-1:0] exp_bp;
    logic [W-1:0] q_exp[$];
    int           sent;
    int           recv;
    int           cyc;
    int           lat;

    initial begin
        // Reset with in_valid high: must not be accepted.
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_uns = 1'b0;
        bus.vra = {4{32'h1111_2222}};
        bus.vrb = {4{32'h3333_4444}};
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_in_ready", W'(bus.in_ready), W'(1'b1));
        check("rst_out_valid", W'(bus.out_valid), W'(1'b0));
        check("rst_busy", W'(bus.busy), W'(1'b0));
        check("rst_vrt", bus.vrt, '0);
        step();
        check("rst_no_accept", W'(bus.busy), W'(1'b0));

        // Saturating corner, signed.
        run_vec("max_pos", {8{16'h7FFF}}, {8{16'h7FFF}}, 1'b0, {8{16'h7FFF}});

        // Mixed halfword corners, signed then unsigned.
        run_vec("mix_s",
                {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000},
                {16'h7FFF, 16'h8000, 16'h0000, 16'h0002, 16'hFFFF, 16'h0001, 16'h4321, 16'h0000},
                1'b0,
                {16'h7FFF, 16'h8000, 16'h0000, 16'h0002, 16'hC000, 16'h0000, 16'h2AAB, 16'h0000});
        run_vec("mix_u",
                {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000},
                {16'h7FFF, 16'h8000, 16'h0000, 16'h0002, 16'hFFFF, 16'h0001, 16'h4321, 16'h0000},
                1'b1,
                {16'h7FFF, 16'h8000, 16'h8000, 16'h0002, 16'hC000, 16'h8000, 16'h2AAB, 16'h0000});
        run_vec("neg1_s", {8{16'hFFFF}}, {8{16'h0001}}, 1'b0, {8{16'h0000}});
        run_vec("neg1_u", {8{16'hFFFF}}, {8{16'h0001}}, 1'b1, {8{16'h8000}});

        // Backpressure: result holds, new requests ignored while DONE.
        exp_bp = {8{16'h1801}};
        bus.vra = {8{16'h1000}};
        bus.vrb = {8{16'h2001}};
        bus.in_uns = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp_done", W'(bus.out_valid), W'(1'b1));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.vra = rand_vec();
            bus.vrb = rand_vec();
            step();
            check("bp_ov", W'(bus.out_valid), W'(1'b1));
            check("bp_vrt", bus.vrt, exp_bp);
            check("bp_in_ready", W'(bus.in_ready), W'(1'b0));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_release_ov", W'(bus.out_valid), W'(1'b0));
        check("bp_release_rdy", W'(bus.in_ready), W'(1'b1));

        // Operands scrambled during RUN must not affect the result.
        sa = rand_vec();
        sb = rand_vec();
        su = 1'b1;
        bus.vra = sa;
        bus.vrb = sb;
        bus.in_uns = su;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            bus.vra = rand_vec();
            bus.vrb = rand_vec();
            bus.in_uns = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        check("scramble_lat", W'(lat), W'(5));
        check("scramble_vrt", bus.vrt, ref_avg(sa, sb, su));
        step();

        // Reset at RUN beat 2 discards the operation.
        bus.vra = {8{16'h5555}};
        bus.vrb = {8{16'h3333}};
        bus.in_uns = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_rdy", W'(bus.in_ready), W'(1'b1));
        check("mid_rst_ov", W'(bus.out_valid), W'(1'b0));
        check("mid_rst_vrt", bus.vrt, '0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid_rst_quiet", W'(bus.out_valid), W'(1'b0));
        end
        run_vec("post_rst", {8{16'h0004}}, {8{16'h0007}}, 1'b0, {8{16'h0006}});

        // Random stream with random valid/ready against the reference queue.
        sent = 0;
        recv = 0;
        cyc = 0;
        bus.in_valid = 1'b0;
        while ((sent < 1000 || q_exp.size() > 0) && cyc < 40000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                check("stream_expected", W'(q_exp.size() > 0), W'(1'b1));
                if (q_exp.size() > 0) begin
                    check("stream_vrt", bus.vrt, q_exp.pop_front());
                end
                recv++;
            end
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                bus.vra = rand_vec();
                bus.vrb = rand_vec();
                bus.in_uns = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    q_exp.push_back(ref_avg(bus.vra, bus.vrb, bus.in_uns));
                    sent++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_sent", W'(sent), W'(1000));
        check("stream_recv", W'(recv), W'(1000));
        check("stream_drained", W'(q_exp.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
